// File: rtl/envelope_mixer.sv
// ============================================================================
// envelope_mixer
//
// Polyphonic envelope mixer. Each voice runs its own attack / sustain /
// release envelope, expressed as a right-shift attenuation "sh" applied to its
// sample. Voice contributions are summed at full precision and averaged over
// the voice count into a registered output.
//
// Ports:
//   clk      in   1               sole clock, all state on posedge
//   reset    in   1               synchronous, active-high
//   samples  in   VOICES*WIDTH    unsigned voice samples, voice v at [v*WIDTH +: WIDTH]
//   gate     in   VOICES          per-voice key-held flag
//   wave     out  WIDTH           registered average of attenuated voices
//   active   out  VOICES          bit v high while voice v is not IDLE
// ============================================================================
module envelope_mixer #(
    parameter int VOICES      = 4,
    parameter int WIDTH       = 8,
    parameter int STEP_CYCLES = 2500000,
    parameter int MAX_SHIFT   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [VOICES*WIDTH-1:0]   samples,
    input  logic [VOICES-1:0]         gate,
    output logic [WIDTH-1:0]          wave,
    output logic [VOICES-1:0]         active
);

    localparam int LOG_V = $clog2(VOICES);
    localparam int SUM_W = WIDTH + LOG_V;
    localparam int SH_W  = $clog2(MAX_SHIFT + 1);
    localparam int CNT_W = $clog2(STEP_CYCLES);

    localparam logic [SH_W-1:0]  SH_MAX   = SH_W'(MAX_SHIFT);
    localparam logic [SH_W-1:0]  SH_ONE   = SH_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } voice_state_t;

    logic [WIDTH-1:0] contrib [VOICES];

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
            voice_state_t     state_reg, state_next;
            logic [SH_W-1:0]  sh_reg, sh_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [WIDTH-1:0] sample;
            logic [WIDTH-1:0] contrib_v;
            logic             active_v;

            assign sample = samples[gi*WIDTH +: WIDTH];

            // State register
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= ST_IDLE;
                    sh_reg    <= SH_MAX;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    sh_reg    <= sh_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Next-state logic. A gate change always wins over a step landing
            // on the same cycle, so the level is frozen at the moment of the
            // transition. The shift updates saturate, which also covers the
            // corner cases of retriggering at sh=0 or releasing at sh=MAX.
            always_comb begin
                state_next = state_reg;
                sh_next    = sh_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    ST_IDLE: begin
                        sh_next  = SH_MAX;
                        cnt_next = '0;
                        if (gate[gi]) begin
                            state_next = ST_ATTACK;
                        end
                    end
                    ST_ATTACK: begin
                        if (!gate[gi]) begin
                            state_next = ST_RELEASE;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            cnt_next = '0;
                            if (sh_reg <= SH_ONE) begin
                                sh_next    = '0;
                                state_next = ST_SUSTAIN;
                            end else begin
                                sh_next = sh_reg - SH_ONE;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    ST_SUSTAIN: begin
                        sh_next  = '0;
                        cnt_next = '0;
                        if (!gate[gi]) begin
                            state_next = ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (gate[gi]) begin
                            state_next = ST_ATTACK;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            cnt_next = '0;
                            if (sh_reg >= SH_MAX - SH_ONE) begin
                                sh_next    = SH_MAX;
                                state_next = ST_IDLE;
                            end else begin
                                sh_next = sh_reg + SH_ONE;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        sh_next    = SH_MAX;
                        cnt_next   = '0;
                    end
                endcase
            end

            // Outputs come straight from the registered state. A shift of
            // WIDTH (the silent level when MAX_SHIFT = WIDTH) yields zero.
            always_comb begin
                active_v  = (state_reg != ST_IDLE);
                contrib_v = '0;
                if (state_reg != ST_IDLE) begin
                    contrib_v = sample >> sh_reg;
                end
            end

            assign active[gi]   = active_v;
            assign contrib[gi]  = contrib_v;
        end
    endgenerate

    // Full-precision sum: VOICES values of WIDTH bits cannot exceed
    // WIDTH + log2(VOICES) bits.
    logic [SUM_W-1:0] sum_next;
    logic [WIDTH-1:0] wave_reg;

    always_comb begin
        sum_next = '0;
        for (int v = 0; v < VOICES; v++) begin
            sum_next = sum_next + SUM_W'(contrib[v]);
        end
    end

    // Dropping the low log2(VOICES) bits is the exact average.
    always_ff @(posedge clk) begin
        if (reset) begin
            wave_reg <= '0;
        end else begin
            wave_reg <= sum_next[SUM_W-1 -: WIDTH];
        end
    end

    assign wave = wave_reg;

endmodule

// File: doc/envelope_mixer.md
ENVELOPE_MIXER -- requirements
Module: envelope_mixer

Interface
REQ-001 Parameter VOICES, default 4: number of independent voices; SHALL be a power of two, 1..16.
REQ-002 Parameter WIDTH, default 8: sample and output bit width.
REQ-003 Parameter STEP_CYCLES, default 2500000: clk cycles per envelope shift step; SHALL be >= 2.
REQ-004 Parameter MAX_SHIFT, default 8: silent attenuation shift; SHALL be 1..WIDTH.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 samples  input  VOICES*WIDTH  unsigned voice samples, packed; voice v at bits [v*WIDTH +: WIDTH].
REQ-008 gate  input  VOICES  per-voice key-held flag, bit v for voice v.
REQ-009 wave  output  WIDTH  registered mixed, attenuated output.
REQ-010 active  output  VOICES  bit v high when voice v state is not IDLE.

Function
REQ-011 Each voice SHALL hold a state (IDLE, ATTACK, SUSTAIN, RELEASE), a shift sh (0..MAX_SHIFT) and a step counter cnt (0..STEP_CYCLES-1), fully independent of the other voices.
REQ-012 IDLE: sh = MAX_SHIFT, cnt = 0; gate[v] high -> ATTACK with cnt = 0 next cycle.
REQ-013 ATTACK: cnt increments each cycle; when cnt = STEP_CYCLES-1, cnt -> 0 and sh -> sh-1; the step that makes sh 0 SHALL move the voice to SUSTAIN in the same update.
REQ-014 ATTACK: gate[v] low -> RELEASE with cnt = 0, sh unchanged; this takes priority over a coincident step.
REQ-015 SUSTAIN: sh = 0, cnt held at 0; gate[v] low -> RELEASE with cnt = 0.
REQ-016 RELEASE: cnt increments; when cnt = STEP_CYCLES-1, cnt -> 0 and sh -> sh+1; the step that makes sh MAX_SHIFT SHALL move the voice to IDLE.
REQ-017 RELEASE: gate[v] high -> ATTACK with cnt = 0, sh unchanged (retrigger resumes from current level); this takes priority over a coincident step.
REQ-018 Voice contribution c[v] = samples[v] >> sh[v] when state != IDLE, else 0; sh = MAX_SHIFT = WIDTH yields 0.
REQ-019 Sum SHALL be computed at WIDTH + log2(VOICES) bits, with no overflow possible.
REQ-020 wave SHALL register sum >> log2(VOICES) each cycle: an exact average, always fitting in WIDTH bits.
REQ-021 Latency: wave at cycle t+1 reflects samples at cycle t and voice state/sh registered at the start of cycle t (one-cycle pipeline).
REQ-022 active[v] SHALL be driven directly from the registered voice state, with no extra delay.
REQ-023 Full-scale attack and full-scale release SHALL each take exactly MAX_SHIFT*STEP_CYCLES cycles.

Reset
REQ-024 While reset is high at a posedge: every voice -> IDLE, sh = MAX_SHIFT, cnt = 0; wave = 0; active = 0.
REQ-025 Reset SHALL override gate and any step in progress, including mid-ATTACK and mid-RELEASE.
REQ-026 The first cycle after reset deasserts SHALL sample gate normally; a gate held high through reset SHALL start ATTACK on that cycle.

Verification
(All scenarios use VOICES=4, WIDTH=8, STEP_CYCLES=4, MAX_SHIFT=8.)
REQ-027 Basic attack: samples[0]=0x80 constant, gate=0001 at cycle 0 and held -> active=0001 from cycle 1; sh reaches 0 after 32 ATTACK cycles; wave then settles at 0x20.
REQ-028 Full mix: all four samples=0xFF, all gates held through SUSTAIN -> wave=0xFF; all gates dropped -> after 32 cycles active=0000 and wave=0x00.
REQ-029 Early release: gate[1] high for 10 cycles then low -> voice 1 enters RELEASE at sh=6, rises back to 8, and is IDLE 8 cycles later; it never enters SUSTAIN.
REQ-030 Retrigger: drop gate[2] in SUSTAIN, re-raise it after 9 RELEASE cycles (sh=2) -> ATTACK resumes from sh=2 and reaches SUSTAIN after 8 more cycles.
REQ-031 Reset mid-operation: assert reset for 1 cycle with voices in ATTACK and SUSTAIN -> next cycle wave=0 and active=0000; voices with gate still high restart ATTACK at sh=8.
REQ-032 Independence and coincidence: gates raised on different cycles each follow their own timeline; gate toggled on the same cycle as a step boundary follows REQ-014/REQ-017 priority.
